ifstmt_eval_seq: RTL and testbench

- Clocked, handshaked evaluator for a nested if/else decision chain on a 32-bit integer operand x.
- Computes intermediate y and result a = z over fixed pipeline states.
- Sits directly downstream of the combinational/initial-block if-statement testcases and consumes a word of the same width and meaning.
- Serves as the sequential, FSM-based counterpart for the if-statement transformation passes.

---
 rtl/ifstmt_eval_seq.sv | 132 +++++++++++++
 tb/tb_ifstmt_eval_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ifstmt_eval_seq.sv
// Handshaked FSM evaluating a nested if/else chain on x; result valid 2 edges after accept, held until out_ready.
// IFSTMT_EVAL_TRACE_EN adds simulation-only logging of results and dropped words.
module ifstmt_eval_seq #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_y,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_Y = 2'd1,
    SEL_Z  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     y_q;
  logic [WIDTH-1:0]     z_q;
  logic [WIDTH-1:0]     out_a_q;
  logic [WIDTH-1:0]     out_y_q;
  logic                 out_valid_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic [WIDTH-1:0]     y_d;
  logic [WIDTH-1:0]     z_d;

  always_comb begin
    y_d = '0;
    if (x_q == WIDTH'(1)) begin
      y_d = x_q + WIDTH'(3);
    end
  end

  // The y==2 arm can never fire; the nested form is kept deliberately so the
  // if-transformation passes see the original shape.
  always_comb begin
    z_d = z_q;
    if (x_q == WIDTH'(1)) begin
      if (y_q == WIDTH'(2)) begin
        z_d = x_q;
      end else begin
        z_d = x_q;
      end
      z_d = x_q + WIDTH'(1);
    end else begin
      z_d = x_q + WIDTH'(2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      out_a_q     <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= in_x;
            y_q     <= '0;
            state_q <= LOAD_Y;
          end
        end
        LOAD_Y: begin
          y_q     <= y_d;
          state_q <= SEL_Z;
        end
        SEL_Z: begin
          z_q         <= z_d;
          out_a_q     <= z_d;
          out_y_q     <= y_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (count_q != {CNT_WIDTH{1'b1}}) begin
              count_q <= count_q + CNT_WIDTH'(1);
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_y     = out_y_q;
  assign count     = count_q;

`ifdef IFSTMT_EVAL_TRACE_EN
  // busy sampled on the clock so the reset edge sees the pre-reset state.
  logic busy_seen_q;

  always @(posedge clk) begin
    busy_seen_q <= busy;
    if (out_valid && out_ready) begin
      $display("a=%0d", out_a);
    end
  end

  always @(negedge rst_n) begin
    if (busy_seen_q) begin
      $display("drop");
    end
  end
`else
`endif

endmodule

// File: tb/tb_ifstmt_eval_seq.sv
// Directed bench for ifstmt_eval_seq: latency, arithmetic wrap, backpressure, mid-op reset, saturation.
module tb_ifstmt_eval_seq;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_x;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_a;
  logic [WIDTH-1:0]     out_y;
  logic                 busy;
  logic [CNT_WIDTH-1:0] count;

  int n_checks;
  int n_fail;

  ifstmt_eval_seq #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_y     (out_y),
    .busy      (busy),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with out_ready=1; checks latency, result and count.
  task automatic send_word(input logic [31:0] x, input logic [31:0] exp_a,
                           input logic [31:0] exp_y, input logic [31:0] exp_cnt);
    in_valid = 1'b1;
    in_x     = x;
    tick();
    in_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("e1_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("e2_out_valid", 32'(out_valid), 32'd1);
    check("out_a", out_a, exp_a);
    check("out_y", out_y, exp_y);
    tick();
    check("done_out_valid", 32'(out_valid), 32'd0);
    check("done_count", 32'(count), exp_cnt);
    check("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int valid_cycles;
    int bad_a;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    #23;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_y", out_y, 32'd0);
    tick();

    send_word(32'd1, 32'd2, 32'd4, 32'd1);
    send_word(32'd0, 32'd2, 32'd0, 32'd2);
    send_word(32'd5, 32'd7, 32'd0, 32'd3);
    send_word(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd4);
    send_word(32'hFFFF_FFFE, 32'd0, 32'd0, 32'd5);
    check("idle_holds_out_a", out_a, 32'd0);

    // Backpressure with a second word waiting on in_valid throughout HOLD.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 32'd10;
    tick();
    in_x = 32'd20;
    check("bp_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_a", out_a, 32'd12);
    check("bp_out_y", out_y, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_a", out_a, 32'd12);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_busy", 32'(busy), 32'd1);
      check("bp_hold_count", 32'(count), 32'd5);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_count", 32'(count), 32'd6);
    check("bp_release_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("late_accept_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("late_out_valid", 32'(out_valid), 32'd1);
    check("late_out_a", out_a, 32'd22);
    tick();
    check("late_count", 32'(count), 32'd7);

    // Reset while in SEL_Z.
    in_valid = 1'b1;
    in_x     = 32'd1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_a", out_a, 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    send_word(32'd3, 32'd5, 32'd0, 32'd1);

    // Back-to-back words with in_valid held high.
    valid_cycles = 0;
    bad_a        = 0;
    in_valid     = 1'b1;
    in_x         = 32'd7;
    for (int i = 1; i <= 1200; i++) begin
      tick();
      if (out_valid) begin
        valid_cycles++;
        if (out_a !== 32'd9 || (i % 4) != 3) bad_a++;
      end
    end
    in_valid = 1'b0;
    check("tp_results", 32'(valid_cycles), 32'd300);
    check("tp_spacing_and_value", 32'(bad_a), 32'd0);
    check("tp_count_saturated", 32'(count), 32'd255);
    check("tp_idle_after", 32'(busy), 32'd0);
    tick();
    tick();
    check("tp_no_extra_accept", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
